bcd_count_ctrl: RTL

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 17 +
 rtl/bcd_count_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter controller: FSM states and digit limits.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } bcd_state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the increment chain: adds carry-in, wraps 9 -> 0 with carry-out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] i_d,
  input  logic       i_ci,
  output logic [3:0] o_q,
  output logic       o_co
);

  logic w_at_max;

  assign w_at_max = (i_d == DIGIT_MAX);
  assign o_co     = i_ci & w_at_max;
  assign o_q      = !i_ci ? i_d : (w_at_max ? 4'd0 : i_d + 4'd1);

endmodule

// File: rtl/bcd_count_ctrl.sv
// BCD up-counter controller with preset load, terminal-count compare and auto-reload.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cleared or after reset; waiting for start
// ST_RUN   | counting one step per cycle with tick high
// ST_PAUSE | stopped from RUN; start resumes from the held count
// ST_DONE  | target reached with auto_reload=0; start reloads the preset
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_clear,
  input  logic              cmd_load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic [4*NDIG-1:0] target,
  input  logic              auto_reload,
  input  logic              tick,
  output logic [4*NDIG-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              load_err
);

  bcd_state_t        r_state, w_state_nxt;
  logic [4*NDIG-1:0] r_count, w_count_nxt;
  logic [4*NDIG-1:0] r_preset, w_preset_nxt;
  logic              r_busy, r_done, r_wrap, r_load_err;
  logic              w_done_nxt, w_wrap_nxt, w_load_err_nxt;

  logic [4*NDIG-1:0] w_inc;
  logic [NDIG:0]     w_carry;
  logic              w_load_ok;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .i_d  (r_count[4*g +: 4]),
      .i_ci (w_carry[g]),
      .o_q  (w_inc[4*g +: 4]),
      .o_co (w_carry[g+1])
    );
  end

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bcd_digit_ok(load_val[4*i +: 4])) w_load_ok = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_preset_nxt   = r_preset;
    w_done_nxt     = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;

    if (cmd_clear) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if (cmd_load) begin
      if (w_load_ok) begin
        w_preset_nxt = load_val;
        w_count_nxt  = load_val;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (cmd_stop) begin
      if (r_state == ST_RUN) w_state_nxt = ST_PAUSE;
    end else if (cmd_start && r_state != ST_RUN) begin
      // Start while running falls through so a coincident tick still counts.
      w_state_nxt = ST_RUN;
      if (r_state == ST_DONE) w_count_nxt = r_preset;
    end else if (r_state == ST_RUN && tick) begin
      w_wrap_nxt  = w_carry[NDIG];
      w_count_nxt = w_inc;
      if (w_inc == target) begin
        w_done_nxt = 1'b1;
        if (auto_reload) begin
          w_count_nxt = r_preset;
        end else begin
          w_count_nxt = target;
          w_state_nxt = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_preset   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_preset   <= w_preset_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= w_done_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
